pipeline_fwd_hazard_unit: RTL and testbench
===========================================

# pipeline_fwd_hazard_unit

Produces the operand-forwarding and stall controls consumed by the IDR register stage: `forward_rs1_data/sel`, `forward_rs2_data/sel` and `stall`. It compares the IDC-stage source registers against in-flight destinations in EX, MEM and WB. It forwards the youngest matching result and stalls the front end on load-use and memory-wait hazards. It also tracks hazard state, consecutive-stall watchdog and a stall performance counter.

## Interface
Parameters:
- XLEN, 64, datapath width
- STALL_LIMIT, 64, consecutive stall cycles that trip the watchdog (≥2)
- CNT_W, 32, width of stall_total

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- flush  in  1  squash of instruction in IDC; overrides stall
- rs1_IDC, rs2_IDC  in  5  source register addresses
- is_rs1_used, is_rs2_used  in  1  source actually read
- rd_EX  in  5, rf_wr_en_EX  in  1, is_load_EX  in  1, alu_result_EX  in  XLEN  EX-stage producer
- rd_MEM  in  5, rf_wr_en_MEM  in  1, is_load_MEM  in  1, wb_data_MEM  in  XLEN, dm_rd_valid_MEM  in  1  MEM-stage producer (wb_data_MEM is load data when is_load_MEM)
- rd_WB  in  5, rf_wr_en_WB  in  1, wb_data_WB  in  XLEN  WB-stage producer
- forward_rs1_data, forward_rs2_data  out  XLEN  forwarded operands
- forward_rs1_sel, forward_rs2_sel  out  1  forward valid
- stall  out  1  freeze IDR and earlier stages
- hazard_state  out  2  registered FSM state: 0 RUN, 1 LOAD_USE, 2 MEM_WAIT
- stall_timeout  out  1  sticky watchdog flag
- stall_total  out  CNT_W  total stall cycles since reset, wraps

## Operation
- Match on stage S for source n: rsn_IDC != 0, is_rsn_used, rf_wr_en_S, rd_S == rsn_IDC. x0 is never forwarded and never stalls.
- Forward priority per source: EX (alu_result_EX) > MEM (wb_data_MEM) > WB (wb_data_WB). sel=1 only for a non-stalling match. Otherwise sel=0 and data=0.
- An EX match with is_load_EX is a load-use hazard. Stall, sel=0 for that source, and do not fall through to older stages.
- A MEM match with is_load_MEM and !dm_rd_valid_MEM is a mem-wait hazard. Stall, and do not fall through to WB.
- stall = (lu_hazard | mw_hazard) & !flush. Forwarding outputs are combinational.
- FSM next state:
  - flush → RUN
  - else lu_hazard → LOAD_USE
  - else mw_hazard → MEM_WAIT
  - else RUN
- Typical load-use sequence: RUN→LOAD_USE→RUN, with the load then forwarded from MEM. With slow memory: RUN→LOAD_USE→MEM_WAIT…→RUN.
- consec counter:
  - clears when stall=0
  - increments when stall=1, saturating at STALL_LIMIT
  - sets stall_timeout on the cycle stall=1 while consec==STALL_LIMIT-1
  - stall_timeout holds until reset; flush does not clear it
- stall_total increments by 1 every cycle stall=1 and wraps modulo 2^CNT_W.

## Timing
- Reset (asynchronous, reset=0): hazard_state=RUN, stall_timeout=0, stall_total=0, consec=0. Combinational outputs follow inputs: stall and sel are 0 when all wr_en are 0.
- Forward and stall decisions have zero latency, so they are valid in the same cycle IDR samples them.
- State, counters and flag update on the posedge following the hazard cycle.
- Simultaneous flush and hazard: stall=0, state→RUN, no counter increment, consec clears.
- Both sources hazard in the same cycle: one stall cycle, one increment.
- EX and MEM both match, EX not a load: EX wins. Same for MEM vs WB.
- Reset mid-stall: all state clears immediately and the next cycle begins in RUN.

## Test plan
- EX ALU forward: rd_EX=5, wr_en_EX=1, alu_result_EX=0x1234, rs1_IDC=5 used → forward_rs1_sel=1, data=0x1234, stall=0. Repeat with rs1_IDC=0 → sel=0.
- Priority: rd_EX=rd_MEM=rd_WB=7, data 0xA/0xB/0xC, rs2_IDC=7 → forward_rs2_data=0xA. Drop wr_en_EX → 0xB. Drop wr_en_MEM → 0xC.
- Load-use: is_load_EX, rd_EX=3, rs1_IDC=3 → stall=1 for one cycle, hazard_state=1 next cycle. Next cycle MEM with dm_rd_valid=1, data=0x55 → sel=1, data=0x55, stall=0, stall_total=1.
- Memory wait: load in MEM matching rs2 with dm_rd_valid_MEM=0 for 3 cycles → stall=1 for 3 cycles, hazard_state=2, stall_total=3. Valid on the 4th cycle → stall=0, forwarded data.
- Flush override: load-use hazard with flush=1 → stall=0, hazard_state stays 0, stall_total unchanged.
- Watchdog and reset: STALL_LIMIT=4, hold mem-wait 4 cycles → stall_timeout=1 after the 4th edge and stays 1 after the hazard ends. Assert reset=0 mid-stall → all registered outputs 0 asynchronously.

Source files
------------

// File: rtl/pipeline_fwd_hazard_unit.sv
// Operand forwarding and front-end stall control for the IDR register stage.
// Each IDC source is resolved independently by pipeline_fwd_src. The top
// combines the per-source hazards into one stall and tracks hazard state, a
// consecutive-stall watchdog and a free-running stall counter.

module pipeline_fwd_src #(
  parameter int XLEN = 64
) (
  input  logic [4:0]      rs,
  input  logic            used,
  input  logic [4:0]      rd_ex,
  input  logic            wr_ex,
  input  logic            load_ex,
  input  logic [XLEN-1:0] data_ex,
  input  logic [4:0]      rd_mem,
  input  logic            wr_mem,
  input  logic            load_mem,
  input  logic            rd_valid_mem,
  input  logic [XLEN-1:0] data_mem,
  input  logic [4:0]      rd_wb,
  input  logic            wr_wb,
  input  logic [XLEN-1:0] data_wb,
  output logic            sel,
  output logic [XLEN-1:0] data,
  output logic            lu,
  output logic            mw
);
  logic live, hit_ex, hit_mem, hit_wb;

  // x0 and unread sources never match anything.
  assign live    = used && (rs != 5'd0);
  assign hit_ex  = live && wr_ex  && (rd_ex  == rs);
  assign hit_mem = live && wr_mem && (rd_mem == rs);
  assign hit_wb  = live && wr_wb  && (rd_wb  == rs);

  // Youngest match wins. A matching stage that cannot supply data yet raises
  // a hazard and shadows the older stages.
  always_comb begin
    sel  = 1'b0;
    data = '0;
    lu   = 1'b0;
    mw   = 1'b0;
    if (hit_ex) begin
      if (load_ex) lu = 1'b1;
      else begin
        sel  = 1'b1;
        data = data_ex;
      end
    end else if (hit_mem) begin
      if (load_mem && !rd_valid_mem) mw = 1'b1;
      else begin
        sel  = 1'b1;
        data = data_mem;
      end
    end else if (hit_wb) begin
      sel  = 1'b1;
      data = data_wb;
    end
  end
endmodule

module pipeline_fwd_hazard_unit #(
  parameter int XLEN        = 64,
  parameter int STALL_LIMIT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [4:0]       rs1_IDC,
  input  logic [4:0]       rs2_IDC,
  input  logic             is_rs1_used,
  input  logic             is_rs2_used,
  input  logic [4:0]       rd_EX,
  input  logic             rf_wr_en_EX,
  input  logic             is_load_EX,
  input  logic [XLEN-1:0]  alu_result_EX,
  input  logic [4:0]       rd_MEM,
  input  logic             rf_wr_en_MEM,
  input  logic             is_load_MEM,
  input  logic [XLEN-1:0]  wb_data_MEM,
  input  logic             dm_rd_valid_MEM,
  input  logic [4:0]       rd_WB,
  input  logic             rf_wr_en_WB,
  input  logic [XLEN-1:0]  wb_data_WB,
  output logic [XLEN-1:0]  forward_rs1_data,
  output logic [XLEN-1:0]  forward_rs2_data,
  output logic             forward_rs1_sel,
  output logic             forward_rs2_sel,
  output logic             stall,
  output logic [1:0]       hazard_state,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] stall_total
);
  localparam int NUM_SRC = 2;
  localparam int CW      = $clog2(STALL_LIMIT + 1);
  localparam logic [CW-1:0] LIM    = CW'(STALL_LIMIT);
  localparam logic [CW-1:0] LIM_M1 = CW'(STALL_LIMIT - 1);

  typedef enum logic [1:0] {RUN = 2'd0, LOAD_USE = 2'd1, MEM_WAIT = 2'd2} hz_state_t;

  logic [NUM_SRC-1:0][4:0]      src_rs;
  logic [NUM_SRC-1:0]           src_used;
  logic [NUM_SRC-1:0]           src_sel, src_lu, src_mw;
  logic [NUM_SRC-1:0][XLEN-1:0] src_data;
  logic                         lu_hazard, mw_hazard;
  hz_state_t                    state, state_nxt;
  logic [CW-1:0]                consec;

  assign src_rs   = {rs2_IDC, rs1_IDC};
  assign src_used = {is_rs2_used, is_rs1_used};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    pipeline_fwd_src #(.XLEN(XLEN)) u_src (
      .rs           (src_rs[g]),
      .used         (src_used[g]),
      .rd_ex        (rd_EX),
      .wr_ex        (rf_wr_en_EX),
      .load_ex      (is_load_EX),
      .data_ex      (alu_result_EX),
      .rd_mem       (rd_MEM),
      .wr_mem       (rf_wr_en_MEM),
      .load_mem     (is_load_MEM),
      .rd_valid_mem (dm_rd_valid_MEM),
      .data_mem     (wb_data_MEM),
      .rd_wb        (rd_WB),
      .wr_wb        (rf_wr_en_WB),
      .data_wb      (wb_data_WB),
      .sel          (src_sel[g]),
      .data         (src_data[g]),
      .lu           (src_lu[g]),
      .mw           (src_mw[g])
    );
  end

  assign forward_rs1_sel  = src_sel[0];
  assign forward_rs2_sel  = src_sel[1];
  assign forward_rs1_data = src_data[0];
  assign forward_rs2_data = src_data[1];

  assign lu_hazard    = |src_lu;
  assign mw_hazard    = |src_mw;
  assign stall        = (lu_hazard || mw_hazard) && !flush;
  assign hazard_state = state;

  // Hazard state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  // Next state: flush squashes the instruction, load-use outranks mem-wait.
  always_comb begin
    state_nxt = RUN;
    if (flush)          state_nxt = RUN;
    else if (lu_hazard) state_nxt = LOAD_USE;
    else if (mw_hazard) state_nxt = MEM_WAIT;
  end

  // Consecutive-stall watchdog (sticky until reset) and wrapping stall counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      consec        <= '0;
      stall_timeout <= 1'b0;
      stall_total   <= '0;
    end else if (stall) begin
      stall_total <= stall_total + 1'b1;
      if (consec != LIM)    consec        <= consec + 1'b1;
      if (consec == LIM_M1) stall_timeout <= 1'b1;
    end else begin
      consec <= '0;
    end
  end
endmodule

// File: tb/tb_pipeline_fwd_hazard_unit.sv
// Scoreboard bench for pipeline_fwd_hazard_unit: every driven cycle pushes its
// expected outputs, which are popped and compared mid-cycle.
module tb_pipeline_fwd_hazard_unit;
  localparam int XLEN = 64, STALL_LIMIT = 4, CNT_W = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush;
  logic [4:0] rs1_IDC, rs2_IDC, rd_EX, rd_MEM, rd_WB;
  logic is_rs1_used, is_rs2_used;
  logic rf_wr_en_EX, is_load_EX, rf_wr_en_MEM, is_load_MEM, dm_rd_valid_MEM, rf_wr_en_WB;
  logic [XLEN-1:0] alu_result_EX, wb_data_MEM, wb_data_WB;
  logic [XLEN-1:0] forward_rs1_data, forward_rs2_data;
  logic forward_rs1_sel, forward_rs2_sel, stall, stall_timeout;
  logic [1:0] hazard_state;
  logic [CNT_W-1:0] stall_total;

  pipeline_fwd_hazard_unit #(.XLEN(XLEN), .STALL_LIMIT(STALL_LIMIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .rs1_IDC(rs1_IDC), .rs2_IDC(rs2_IDC), .is_rs1_used(is_rs1_used), .is_rs2_used(is_rs2_used),
    .rd_EX(rd_EX), .rf_wr_en_EX(rf_wr_en_EX), .is_load_EX(is_load_EX), .alu_result_EX(alu_result_EX),
    .rd_MEM(rd_MEM), .rf_wr_en_MEM(rf_wr_en_MEM), .is_load_MEM(is_load_MEM),
    .wb_data_MEM(wb_data_MEM), .dm_rd_valid_MEM(dm_rd_valid_MEM),
    .rd_WB(rd_WB), .rf_wr_en_WB(rf_wr_en_WB), .wb_data_WB(wb_data_WB),
    .forward_rs1_data(forward_rs1_data), .forward_rs2_data(forward_rs2_data),
    .forward_rs1_sel(forward_rs1_sel), .forward_rs2_sel(forward_rs2_sel),
    .stall(stall), .hazard_state(hazard_state), .stall_timeout(stall_timeout),
    .stall_total(stall_total)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           tag;
    logic            sel1, sel2, stall, to;
    logic [XLEN-1:0] d1, d2;
    logic [1:0]      st;
    logic [CNT_W-1:0] tot;
  } exp_t;

  exp_t sbq[$];
  int checks = 0, errors = 0;

  // Reference registered state, advanced once per clock.
  logic [1:0]       m_state = 2'd0;
  logic [CNT_W-1:0] m_tot = '0;
  int               m_consec = 0;
  logic             m_to = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Scan stages youngest-first; the first matching stage decides the outcome.
  function automatic void fwd_model(input logic [4:0] rs, input logic used,
                                    output logic sel, output logic [XLEN-1:0] d,
                                    output logic lu, output logic mw);
    logic [4:0]      rd [3];
    logic            we [3];
    logic [XLEN-1:0] v  [3];
    logic            done;
    rd = '{rd_EX, rd_MEM, rd_WB};
    we = '{rf_wr_en_EX, rf_wr_en_MEM, rf_wr_en_WB};
    v  = '{alu_result_EX, wb_data_MEM, wb_data_WB};
    sel = 0; d = '0; lu = 0; mw = 0; done = 0;
    for (int s = 0; s < 3; s++) begin
      if (!done && rs != 0 && used && we[s] && rd[s] == rs) begin
        done = 1;
        if (s == 0 && is_load_EX) lu = 1;
        else if (s == 1 && is_load_MEM && !dm_rd_valid_MEM) mw = 1;
        else begin sel = 1; d = v[s]; end
      end
    end
  endfunction

  task automatic clr();
    flush = 0; rs1_IDC = 0; rs2_IDC = 0; is_rs1_used = 0; is_rs2_used = 0;
    rd_EX = 0; rf_wr_en_EX = 0; is_load_EX = 0; alu_result_EX = '0;
    rd_MEM = 0; rf_wr_en_MEM = 0; is_load_MEM = 0; wb_data_MEM = '0; dm_rd_valid_MEM = 0;
    rd_WB = 0; rf_wr_en_WB = 0; wb_data_WB = '0;
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
      return;
    end
    e = sbq.pop_front();
    chk({e.tag, ".sel1"},  64'(forward_rs1_sel),  64'(e.sel1));
    chk({e.tag, ".data1"}, forward_rs1_data,      e.d1);
    chk({e.tag, ".sel2"},  64'(forward_rs2_sel),  64'(e.sel2));
    chk({e.tag, ".data2"}, forward_rs2_data,      e.d2);
    chk({e.tag, ".stall"}, 64'(stall),            64'(e.stall));
    chk({e.tag, ".state"}, 64'(hazard_state),     64'(e.st));
    chk({e.tag, ".tmo"},   64'(stall_timeout),    64'(e.to));
    chk({e.tag, ".total"}, 64'(stall_total),      64'(e.tot));
  endtask

  // Inputs are already driven; push the expectation, sample at negedge,
  // then advance the reference state across the next posedge.
  task automatic step(input string tag);
    exp_t e;
    logic lu1, mw1, lu2, mw2, st;
    fwd_model(rs1_IDC, is_rs1_used, e.sel1, e.d1, lu1, mw1);
    fwd_model(rs2_IDC, is_rs2_used, e.sel2, e.d2, lu2, mw2);
    st = (lu1 | lu2 | mw1 | mw2) & !flush;
    e.tag = tag; e.stall = st; e.st = m_state; e.to = m_to; e.tot = m_tot;
    sbq.push_back(e);
    @(negedge clk);
    pop_cmp();
    if (st) begin
      m_tot = m_tot + 1;
      if (m_consec == STALL_LIMIT - 1) m_to = 1;
      if (m_consec < STALL_LIMIT) m_consec++;
    end else m_consec = 0;
    m_state = flush ? 2'd0 : (lu1 | lu2) ? 2'd1 : (mw1 | mw2) ? 2'd2 : 2'd0;
    @(posedge clk); #1;
  endtask

  task automatic mem_wait_rs2(input logic [4:0] r);
    clr(); rs2_IDC = r; is_rs2_used = 1;
    rd_MEM = r; rf_wr_en_MEM = 1; is_load_MEM = 1; dm_rd_valid_MEM = 0; wb_data_MEM = 64'hDEAD;
  endtask

  initial begin
    clr();
    #3;
    chk("rst.state", 64'(hazard_state), 64'd0);
    chk("rst.total", 64'(stall_total), 64'd0);
    chk("rst.tmo",   64'(stall_timeout), 64'd0);
    chk("rst.stall", 64'(stall), 64'd0);
    chk("rst.sel1",  64'(forward_rs1_sel), 64'd0);
    @(posedge clk); #1; reset = 1;

    // EX ALU forward, then x0 suppression.
    rd_EX = 5; rf_wr_en_EX = 1; alu_result_EX = 64'h1234; rs1_IDC = 5; is_rs1_used = 1;
    step("ex_fwd");
    chk("ex_fwd.const", forward_rs1_data, 64'h1234);
    rs1_IDC = 0; rd_EX = 0; is_load_EX = 1;
    step("x0");

    // Priority EX > MEM > WB.
    clr(); rs2_IDC = 7; is_rs2_used = 1;
    rd_EX = 7; rd_MEM = 7; rd_WB = 7; rf_wr_en_EX = 1; rf_wr_en_MEM = 1; rf_wr_en_WB = 1;
    alu_result_EX = 64'hA; wb_data_MEM = 64'hB; wb_data_WB = 64'hC;
    step("prio_ex");
    chk("prio_ex.const", forward_rs2_data, 64'hA);
    rf_wr_en_EX = 0; step("prio_mem");
    chk("prio_mem.const", forward_rs2_data, 64'hB);
    rf_wr_en_MEM = 0; step("prio_wb");
    chk("prio_wb.const", forward_rs2_data, 64'hC);

    // Load-use then forward from MEM.
    clr(); rs1_IDC = 3; is_rs1_used = 1; rd_EX = 3; rf_wr_en_EX = 1; is_load_EX = 1;
    step("lu");
    clr(); rs1_IDC = 3; is_rs1_used = 1;
    rd_MEM = 3; rf_wr_en_MEM = 1; is_load_MEM = 1; dm_rd_valid_MEM = 1; wb_data_MEM = 64'h55;
    step("lu_mem");
    chk("lu.total_const", 64'(stall_total), 64'd1);

    // Memory wait for 3 cycles, then data valid.
    mem_wait_rs2(5'd9);
    for (int i = 0; i < 3; i++) step($sformatf("mw%0d", i));
    dm_rd_valid_MEM = 1; wb_data_MEM = 64'h77;
    step("mw_done");
    chk("mw.total_const", 64'(stall_total), 64'd4);

    // Flush overrides a load-use hazard.
    clr(); rs1_IDC = 3; is_rs1_used = 1; rd_EX = 3; rf_wr_en_EX = 1; is_load_EX = 1; flush = 1;
    step("flush");
    clr(); step("flush_after");

    // Both sources hazard in one cycle.
    mem_wait_rs2(5'd4);
    rs1_IDC = 6; is_rs1_used = 1; rd_EX = 6; rf_wr_en_EX = 1; is_load_EX = 1;
    step("both");
    clr(); step("both_after");

    // Watchdog: trips on the 4th consecutive stall and stays set.
    mem_wait_rs2(5'd12);
    for (int i = 0; i < 4; i++) step($sformatf("wd%0d", i));
    clr(); step("wd_end0"); step("wd_end1");
    chk("wd.tmo_const", 64'(stall_timeout), 64'd1);

    // Reset mid-stall clears registered state immediately.
    mem_wait_rs2(5'd12);
    step("pre_rst0"); step("pre_rst1");
    reset = 0; #1;
    chk("arst.state", 64'(hazard_state), 64'd0);
    chk("arst.total", 64'(stall_total), 64'd0);
    chk("arst.tmo",   64'(stall_timeout), 64'd0);
    m_state = 0; m_tot = '0; m_consec = 0; m_to = 0;
    @(posedge clk); #1; reset = 1; clr();
    step("post_rst");

    // Random traffic on a small register window.
    for (int i = 0; i < 40; i++) begin
      rs1_IDC = 5'($urandom_range(0, 3)); rs2_IDC = 5'($urandom_range(0, 3));
      is_rs1_used = 1'($urandom); is_rs2_used = 1'($urandom);
      rd_EX = 5'($urandom_range(0, 3)); rf_wr_en_EX = 1'($urandom); is_load_EX = 1'($urandom);
      rd_MEM = 5'($urandom_range(0, 3)); rf_wr_en_MEM = 1'($urandom); is_load_MEM = 1'($urandom);
      dm_rd_valid_MEM = 1'($urandom);
      rd_WB = 5'($urandom_range(0, 3)); rf_wr_en_WB = 1'($urandom);
      alu_result_EX = {$urandom, $urandom}; wb_data_MEM = {$urandom, $urandom};
      wb_data_WB = {$urandom, $urandom};
      flush = ($urandom_range(0, 7) == 0);
      step($sformatf("rnd%0d", i));
    end

    if (sbq.size() != 0) chk("sb_left", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
